bcd_result_decoder: RTL and testbench

// Consumes the 9-bit signed-BCD result produced by the calculator ALU. Converts it to sign-magnitude
// BCD and drives a 3-position multiplexed 7-segment display: sign, tens and ones.
// It is the decode side of the ALU's 10's-complement encoding and sits between the ALU and the display pins.

---
 rtl/bcd_result_decoder.sv | 134 +++++++++++++
 tb/tb_bcd_result_decoder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bcd_result_decoder.sv
// bcd_result_decoder: signed 10's-complement BCD result to sign-magnitude plus 3-position 7-segment scan
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   res_valid, res_ready  result handshake (word accepted when both are high)
//   result[8:0]           {sign, tens BCD, ones BCD}, negative values in 10's-complement form
//   mag[7:0], neg, err    converted magnitude {tens,ones}, sign, undisplayable-word flag
//   busy                  conversion in progress
//   seg[6:0]              {g,f,e,d,c,b,a}, active-high
//   digit_sel[2:0]        one-hot position select: [0]=ones, [1]=tens, [2]=sign
module bcd_result_decoder #(
   parameter int SCAN_DIV = 1000,
   parameter int SCAN_W   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       res_valid,
   output logic       res_ready,
   input  logic [8:0] result,
   output logic [7:0] mag,
   output logic       neg,
   output logic       err,
   output logic       busy,
   output logic [6:0] seg,
   output logic [2:0] digit_sel
);
   typedef enum logic [2:0] {IDLE, CHECK, CONV_LO, CONV_HI, SHOW} state_t;
   state_t state, state_n;
   logic [8:0] res_q, res_n;
   logic [3:0] lo, lo_n, hi, tens, ones;
   logic borrow, borrow_n, sign, bad, show, wrap;
   logic [7:0] mag_n;
   logic neg_n, err_n;
   logic [6:0] seg_n;
   logic [2:0] sel_n;
   logic [SCAN_W-1:0] cnt, cnt_n;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: seg7 = 7'h3F;
         4'd1: seg7 = 7'h06;
         4'd2: seg7 = 7'h5B;
         4'd3: seg7 = 7'h4F;
         4'd4: seg7 = 7'h66;
         4'd5: seg7 = 7'h6D;
         4'd6: seg7 = 7'h7D;
         4'd7: seg7 = 7'h07;
         4'd8: seg7 = 7'h7F;
         4'd9: seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   assign sign = res_q[8];
   assign tens = res_q[7:4];
   assign ones = res_q[3:0];
   assign res_ready = (state == IDLE) || (state == SHOW);
   assign busy = (state == CHECK) || (state == CONV_LO) || (state == CONV_HI);
   // -100 has no 2-digit magnitude, so sign with 00 is rejected along with non-BCD digits
   assign bad = (tens > 4'd9) || (ones > 4'd9) || (sign && tens == 4'd0 && ones == 4'd0);
   assign hi = !sign ? tens : borrow ? 4'd9 - tens : (tens == 4'd0 ? 4'd0 : 4'd10 - tens);

   always_comb begin
      state_n = state;
      res_n = res_q;
      lo_n = lo;
      borrow_n = borrow;
      mag_n = mag;
      neg_n = neg;
      err_n = err;
      case (state)
         IDLE, SHOW: if (res_valid) begin
            res_n = result;
            state_n = CHECK;
         end
         CHECK: if (bad) begin
            err_n = 1'b1;
            mag_n = 8'h00;
            neg_n = 1'b0;
            state_n = SHOW;
         end else begin
            err_n = 1'b0;
            state_n = CONV_LO;
         end
         CONV_LO: begin
            lo_n = !sign ? ones : (ones == 4'd0 ? 4'd0 : 4'd10 - ones);
            borrow_n = sign && ones != 4'd0;
            state_n = CONV_HI;
         end
         CONV_HI: begin
            mag_n = {hi, lo};
            neg_n = sign;
            state_n = SHOW;
         end
         default: state_n = IDLE;
      endcase
   end

   // Display is derived from next-state values so seg and digit_sel stay registered yet consistent
   always_comb begin
      show = state_n == SHOW;
      wrap = cnt == SCAN_W'(SCAN_DIV - 1);
      sel_n = !show ? 3'b000 : state != SHOW ? 3'b001 : wrap ? {digit_sel[1:0], digit_sel[2]} : digit_sel;
      cnt_n = (!show || state != SHOW || wrap) ? '0 : cnt + 1'b1;
      seg_n = sel_n[0] ? (err_n ? 7'h79 : seg7(mag_n[3:0])) :
              sel_n[1] ? ((err_n || mag_n[7:4] == 4'd0) ? 7'h00 : seg7(mag_n[7:4])) :
              sel_n[2] ? (neg_n ? 7'h40 : 7'h00) : 7'h00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         res_q <= '0;
         lo <= '0;
         borrow <= 1'b0;
         mag <= '0;
         neg <= 1'b0;
         err <= 1'b0;
         seg <= '0;
         digit_sel <= '0;
         cnt <= '0;
      end else begin
         state <= state_n;
         res_q <= res_n;
         lo <= lo_n;
         borrow <= borrow_n;
         mag <= mag_n;
         neg <= neg_n;
         err <= err_n;
         seg <= seg_n;
         digit_sel <= sel_n;
         cnt <= cnt_n;
      end
   end
endmodule

// File: tb/tb_bcd_result_decoder.sv
// tb_bcd_result_decoder: directed checks of conversion, error handling, display scan and reset
module tb_bcd_result_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic res_valid = 1'b0;
   logic res_ready;
   logic [8:0] result = '0;
   logic [7:0] mag;
   logic neg, err, busy;
   logic [6:0] seg;
   logic [2:0] digit_sel;
   int errors = 0;
   int checks = 0;

   bcd_result_decoder #(.SCAN_DIV(4), .SCAN_W(2)) dut (
      .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready), .result(result),
      .mag(mag), .neg(neg), .err(err), .busy(busy), .seg(seg), .digit_sel(digit_sel)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [8:0] w);
      result = w;
      res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
   endtask

   task automatic show_pos(input string tag, input logic [2:0] s, input logic [6:0] g, input int n);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_sel"}, 32'(digit_sel), 32'(s));
         chk({tag, "_seg"}, 32'(seg), 32'(g));
         tick();
      end
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(res_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      tick();
      chk("idle_ready", 32'(res_ready), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_seg", 32'(seg), 0);
      chk("idle_sel", 32'(digit_sel), 0);
      chk("idle_mag", 32'(mag), 0);
      chk("idle_neg", 32'(neg), 0);
      chk("idle_err", 32'(err), 0);

      send(9'h045);
      chk("p45_busy", 32'(busy), 1);
      chk("p45_ready", 32'(res_ready), 0);
      chk("p45_seg_blank", 32'(seg), 0);
      chk("p45_sel_blank", 32'(digit_sel), 0);
      tick(2);
      chk("p45_mag_early", 32'(mag), 0);
      tick();
      chk("p45_mag", 32'(mag), 32'h45);
      chk("p45_neg", 32'(neg), 0);
      show_pos("p45_ones", 3'b001, 7'h6D, 4);
      show_pos("p45_tens", 3'b010, 7'h66, 4);
      show_pos("p45_sign", 3'b100, 7'h00, 4);
      show_pos("p45_wrap", 3'b001, 7'h6D, 1);

      send(9'h173);
      tick(3);
      chk("n27_mag", 32'(mag), 32'h27);
      chk("n27_neg", 32'(neg), 1);
      show_pos("n27_ones", 3'b001, 7'h07, 4);
      show_pos("n27_tens", 3'b010, 7'h5B, 4);
      show_pos("n27_sign", 3'b100, 7'h40, 1);

      send(9'h190);
      tick(2);
      chk("n10_mag_early", 32'(mag), 32'h27);
      tick();
      chk("n10_mag", 32'(mag), 32'h10);
      chk("n10_neg", 32'(neg), 1);

      send(9'h100);
      tick(2);
      chk("n00_err", 32'(err), 1);
      chk("n00_mag", 32'(mag), 0);
      chk("n00_neg", 32'(neg), 0);
      chk("n00_busy", 32'(busy), 0);
      chk("n00_ones_sel", 32'(digit_sel), 32'b001);
      chk("n00_ones_seg", 32'(seg), 32'h79);
      tick(3);
      show_pos("n00_tens", 3'b010, 7'h00, 1);
      tick(3);
      show_pos("n00_sign", 3'b100, 7'h00, 1);

      send(9'h0A3);
      chk("bad_busy_t0", 32'(busy), 1);
      tick(2);
      chk("bad_err", 32'(err), 1);
      chk("bad_busy", 32'(busy), 0);
      chk("bad_ready", 32'(res_ready), 1);

      send(9'h009);
      tick(3);
      chk("p09_err", 32'(err), 0);
      chk("p09_mag", 32'(mag), 32'h09);
      chk("p09_neg", 32'(neg), 0);
      show_pos("p09_ones", 3'b001, 7'h6F, 4);
      show_pos("p09_tens", 3'b010, 7'h00, 1);

      result = 9'h045;
      res_valid = 1'b1;
      tick();
      chk("hold_busy_check", 32'(busy), 1);
      tick();
      chk("hold_ready_lo", 32'(res_ready), 0);
      result = 9'h012;
      tick();
      chk("hold_busy_hi", 32'(busy), 1);
      chk("hold_ready_hi", 32'(res_ready), 0);
      rst = 1'b1;
      #1;
      chk("arst_ready", 32'(res_ready), 1);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_mag", 32'(mag), 0);
      chk("arst_neg", 32'(neg), 0);
      chk("arst_err", 32'(err), 0);
      chk("arst_seg", 32'(seg), 0);
      chk("arst_sel", 32'(digit_sel), 0);
      res_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_ready", 32'(res_ready), 1);
      chk("post_busy", 32'(busy), 0);
      chk("post_mag", 32'(mag), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
